// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the 64-bit ALU: decodes the ALU operation code,
// forwards operands from EX/MEM and MEM/WB, and raises the load-use stall request.
module id_ex_stage #(
  parameter int XLEN = 64,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            flush,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic [RA_W-1:0] id_rd,
  input  logic [2:0]      id_funct3,
  input  logic            id_funct7_5,
  input  logic [1:0]      id_alu_op,
  input  logic            id_alu_src,
  input  logic            id_reg_write,
  input  logic            id_mem_read,
  input  logic            id_mem_write,
  input  logic            id_branch,
  input  logic            id_mem_to_reg,
  input  logic            exmem_reg_write,
  input  logic [RA_W-1:0] exmem_rd,
  input  logic [XLEN-1:0] exmem_result,
  input  logic            memwb_reg_write,
  input  logic [RA_W-1:0] memwb_rd,
  input  logic [XLEN-1:0] memwb_result,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_a,
  output logic [XLEN-1:0] ex_b,
  output logic [3:0]      ex_aluop,
  output logic [XLEN-1:0] ex_store_data,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_imm,
  output logic [RA_W-1:0] ex_rd,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_branch,
  output logic            ex_mem_to_reg,
  output logic            ex_illegal,
  output logic            load_use_stall
);

  logic            valid_q;
  logic [XLEN-1:0] pc_q, rs1_data_q, rs2_data_q, imm_q;
  logic [RA_W-1:0] rs1_q, rs2_q, rd_q;
  logic [3:0]      aluop_q;
  logic            alu_src_q, illegal_q;
  logic            reg_write_q, mem_read_q, mem_write_q, branch_q, mem_to_reg_q;

  logic [3:0]      aluop_d;
  logic            illegal_d;
  logic            ctl_ok;
  logic [XLEN-1:0] fwd_a, fwd_b;

  always_comb begin
    aluop_d   = 4'b0010;
    illegal_d = 1'b0;
    case (id_alu_op)
      2'b00: aluop_d = 4'b0010;
      2'b01: aluop_d = 4'b0110;
      2'b10: begin
        case (id_funct3)
          3'b000:  aluop_d = id_funct7_5 ? 4'b0110 : 4'b0010;
          3'b111:  aluop_d = 4'b0000;
          3'b110:  aluop_d = 4'b0001;
          default: illegal_d = 1'b1;
        endcase
      end
      default: begin
        case (id_funct3)
          3'b000:  aluop_d = 4'b0010;
          3'b111:  aluop_d = 4'b0000;
          3'b110:  aluop_d = 4'b0001;
          default: illegal_d = 1'b1;
        endcase
      end
    endcase
  end

  // An illegal op must not write state or redirect; mem_to_reg only steers the WB mux
  assign ctl_ok = id_valid & ~illegal_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q      <= 1'b0;
      pc_q         <= '0;
      rs1_data_q   <= '0;
      rs2_data_q   <= '0;
      imm_q        <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      rd_q         <= '0;
      aluop_q      <= 4'b0000;
      alu_src_q    <= 1'b0;
      illegal_q    <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      branch_q     <= 1'b0;
      mem_to_reg_q <= 1'b0;
    end else if (flush) begin
      valid_q      <= 1'b0;
      illegal_q    <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      branch_q     <= 1'b0;
      mem_to_reg_q <= 1'b0;
    end else if (!stall) begin
      valid_q      <= id_valid;
      pc_q         <= id_pc;
      rs1_data_q   <= id_rs1_data;
      rs2_data_q   <= id_rs2_data;
      imm_q        <= id_imm;
      rs1_q        <= id_rs1;
      rs2_q        <= id_rs2;
      rd_q         <= id_rd;
      aluop_q      <= aluop_d;
      alu_src_q    <= id_alu_src;
      illegal_q    <= id_valid & illegal_d;
      reg_write_q  <= ctl_ok & id_reg_write;
      mem_read_q   <= ctl_ok & id_mem_read;
      mem_write_q  <= ctl_ok & id_mem_write;
      branch_q     <= ctl_ok & id_branch;
      mem_to_reg_q <= id_valid & id_mem_to_reg;
    end
  end

  // EX/MEM is the younger producer, so it takes precedence over MEM/WB
  always_comb begin
    fwd_a = rs1_data_q;
    if (rs1_q != '0) begin
      if (exmem_reg_write && exmem_rd == rs1_q)
        fwd_a = exmem_result;
      else if (memwb_reg_write && memwb_rd == rs1_q)
        fwd_a = memwb_result;
    end
  end

  always_comb begin
    fwd_b = rs2_data_q;
    if (rs2_q != '0) begin
      if (exmem_reg_write && exmem_rd == rs2_q)
        fwd_b = exmem_result;
      else if (memwb_reg_write && memwb_rd == rs2_q)
        fwd_b = memwb_result;
    end
  end

  assign ex_a          = fwd_a;
  assign ex_b          = alu_src_q ? imm_q : fwd_b;
  assign ex_store_data = fwd_b;
  assign ex_valid      = valid_q;
  assign ex_aluop      = aluop_q;
  assign ex_pc         = pc_q;
  assign ex_imm        = imm_q;
  assign ex_rd         = rd_q;
  assign ex_reg_write  = reg_write_q;
  assign ex_mem_read   = mem_read_q;
  assign ex_mem_write  = mem_write_q;
  assign ex_branch     = branch_q;
  assign ex_mem_to_reg = mem_to_reg_q;
  assign ex_illegal    = illegal_q;

  assign load_use_stall = valid_q && mem_read_q && (rd_q != '0) &&
                          ((rd_q == id_rs1) || (rd_q == id_rs2)) && id_valid;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: decode vector table plus hand-written sequences
// for forwarding, load-use, stall/flush and asynchronous reset.
module tb_id_ex_stage;

  logic        clk, rst_n, stall, flush, id_valid;
  logic [63:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [2:0]  id_funct3;
  logic        id_funct7_5;
  logic [1:0]  id_alu_op;
  logic        id_alu_src, id_reg_write, id_mem_read, id_mem_write, id_branch, id_mem_to_reg;
  logic        exmem_reg_write, memwb_reg_write;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [63:0] exmem_result, memwb_result;
  logic        ex_valid;
  logic [63:0] ex_a, ex_b, ex_store_data, ex_pc, ex_imm;
  logic [3:0]  ex_aluop;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_mem_to_reg;
  logic        ex_illegal, load_use_stall;

  int n_tests = 0;
  int n_fail  = 0;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_funct3(id_funct3), .id_funct7_5(id_funct7_5), .id_alu_op(id_alu_op),
    .id_alu_src(id_alu_src), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_branch(id_branch), .id_mem_to_reg(id_mem_to_reg),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b), .ex_aluop(ex_aluop),
    .ex_store_data(ex_store_data), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_branch(ex_branch), .ex_mem_to_reg(ex_mem_to_reg), .ex_illegal(ex_illegal),
    .load_use_stall(load_use_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ctl/ectl bit order: {reg_write, mem_read, mem_write, branch, mem_to_reg}
  typedef struct {
    logic       v;
    logic [1:0] op;
    logic [2:0] f3;
    logic       f7;
    logic [4:0] ctl;
    logic       ev;
    logic [3:0] ea;
    logic       ei;
    logic [4:0] ectl;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mkv(input logic v, input logic [1:0] op, input logic [2:0] f3,
                               input logic f7, input logic [4:0] ctl, input logic ev,
                               input logic [3:0] ea, input logic ei, input logic [4:0] ectl);
    vec_t r;
    r.v = v; r.op = op; r.f3 = f3; r.f7 = f7; r.ctl = ctl;
    r.ev = ev; r.ea = ea; r.ei = ei; r.ectl = ectl;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic id_clear;
    id_valid = 0; id_pc = 0; id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
    id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_funct3 = 0; id_funct7_5 = 0; id_alu_op = 0;
    id_alu_src = 0; id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
    id_branch = 0; id_mem_to_reg = 0;
  endtask

  function automatic logic [4:0] ctl_out();
    return {ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_mem_to_reg};
  endfunction

  initial begin
    vecs[0]  = mkv(1, 2'b00, 3'b101, 0, 5'b10000, 1, 4'b0010, 0, 5'b10000);
    vecs[1]  = mkv(1, 2'b01, 3'b000, 0, 5'b00010, 1, 4'b0110, 0, 5'b00010);
    vecs[2]  = mkv(1, 2'b10, 3'b000, 0, 5'b10000, 1, 4'b0010, 0, 5'b10000);
    vecs[3]  = mkv(1, 2'b10, 3'b000, 1, 5'b10000, 1, 4'b0110, 0, 5'b10000);
    vecs[4]  = mkv(1, 2'b10, 3'b111, 0, 5'b10000, 1, 4'b0000, 0, 5'b10000);
    vecs[5]  = mkv(1, 2'b10, 3'b110, 1, 5'b10000, 1, 4'b0001, 0, 5'b10000);
    vecs[6]  = mkv(1, 2'b11, 3'b000, 1, 5'b10000, 1, 4'b0010, 0, 5'b10000);
    vecs[7]  = mkv(1, 2'b11, 3'b111, 0, 5'b10000, 1, 4'b0000, 0, 5'b10000);
    vecs[8]  = mkv(1, 2'b11, 3'b110, 0, 5'b10000, 1, 4'b0001, 0, 5'b10000);
    vecs[9]  = mkv(1, 2'b11, 3'b001, 0, 5'b10000, 1, 4'b0010, 1, 5'b00000);
    vecs[10] = mkv(1, 2'b10, 3'b100, 0, 5'b11111, 1, 4'b0010, 1, 5'b00001);
    vecs[11] = mkv(1, 2'b10, 3'b000, 1, 5'b01001, 1, 4'b0110, 0, 5'b01001);
    vecs[12] = mkv(0, 2'b00, 3'b000, 0, 5'b11111, 0, 4'b0010, 0, 5'b00000);
    vecs[13] = mkv(0, 2'b10, 3'b011, 0, 5'b11111, 0, 4'b0010, 0, 5'b00000);
    vecs[14] = mkv(1, 2'b10, 3'b101, 1, 5'b00000, 1, 4'b0010, 1, 5'b00000);

    // Reset held while ID presents a live instruction: nothing may load
    rst_n = 0; stall = 0; flush = 0;
    exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
    memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
    id_clear();
    id_valid = 1; id_pc = 64'h40; id_alu_op = 2'b10; id_funct7_5 = 1; id_reg_write = 1;
    tick(); tick();
    chk("rst ex_valid", ex_valid, 0);
    chk("rst ex_aluop", ex_aluop, 0);
    chk("rst ctl", ctl_out(), 0);
    chk("rst ex_illegal", ex_illegal, 0);
    chk("rst ex_pc", ex_pc, 0);
    chk("rst ex_a", ex_a, 0);
    chk("rst load_use_stall", load_use_stall, 0);

    @(negedge clk);
    rst_n = 1;
    tick();
    chk("first ex_valid", ex_valid, 1);
    chk("first ex_aluop", ex_aluop, 4'b0110);
    chk("first ex_pc", ex_pc, 64'h40);

    for (int i = 0; i < 15; i++) begin
      id_clear();
      id_valid = vecs[i].v; id_alu_op = vecs[i].op; id_funct3 = vecs[i].f3;
      id_funct7_5 = vecs[i].f7; id_pc = 64'h1000 + 64'(i * 4);
      {id_reg_write, id_mem_read, id_mem_write, id_branch, id_mem_to_reg} = vecs[i].ctl;
      tick();
      chk($sformatf("vec%0d valid", i), ex_valid, vecs[i].ev);
      chk($sformatf("vec%0d aluop", i), ex_aluop, vecs[i].ea);
      chk($sformatf("vec%0d illegal", i), ex_illegal, vecs[i].ei);
      chk($sformatf("vec%0d ctl", i), ctl_out(), vecs[i].ectl);
      chk($sformatf("vec%0d pc", i), ex_pc, 64'h1000 + 64'(i * 4));
    end

    // Forwarding priority on rs1
    id_clear();
    id_valid = 1; id_rs1 = 5; id_rs1_data = 64'h1111; id_rs2 = 7; id_rs2_data = 64'h2222;
    exmem_reg_write = 1; exmem_rd = 5; exmem_result = 64'hAAAA;
    memwb_reg_write = 1; memwb_rd = 5; memwb_result = 64'hBBBB;
    tick();
    chk("fwd exmem wins", ex_a, 64'hAAAA);
    chk("fwd rs2 no match", ex_b, 64'h2222);
    exmem_reg_write = 0;
    #1;
    chk("fwd memwb", ex_a, 64'hBBBB);
    memwb_reg_write = 0;
    #1;
    chk("fwd none", ex_a, 64'h1111);
    id_rs1 = 0; id_rs1_data = 64'h3333;
    exmem_reg_write = 1; exmem_rd = 0; memwb_reg_write = 1; memwb_rd = 0;
    tick();
    chk("fwd x0 blocked", ex_a, 64'h3333);

    // Immediate select vs forwarded store data
    id_clear();
    id_valid = 1; id_rs2 = 9; id_rs2_data = 64'h5555; id_imm = 64'h10; id_alu_src = 1;
    exmem_reg_write = 1; exmem_rd = 9; exmem_result = 64'h77;
    memwb_reg_write = 0;
    tick();
    chk("alu_src ex_b", ex_b, 64'h10);
    chk("alu_src store", ex_store_data, 64'h77);
    chk("alu_src ex_imm", ex_imm, 64'h10);
    id_alu_src = 0;
    tick();
    chk("reg ex_b fwd", ex_b, 64'h77);
    exmem_reg_write = 0;

    // Load-use detection, then combined stall+flush bubble
    id_clear();
    id_valid = 1; id_rd = 3; id_mem_read = 1; id_reg_write = 1; id_mem_to_reg = 1;
    id_pc = 64'h1800;
    tick();
    id_clear();
    id_valid = 1; id_rs1 = 1; id_rs2 = 3; id_pc = 64'h2000; id_alu_op = 2'b01;
    id_reg_write = 1;
    #1;
    chk("lu hit rs2", load_use_stall, 1);
    id_rs2 = 4;
    #1;
    chk("lu miss", load_use_stall, 0);
    id_rs2 = 3; id_valid = 0;
    #1;
    chk("lu id invalid", load_use_stall, 0);
    id_valid = 1;
    stall = 1; flush = 1;
    tick();
    chk("bubble valid", ex_valid, 0);
    chk("bubble ctl", ctl_out(), 0);
    chk("bubble no reload pc", ex_pc, 64'h1800);
    chk("bubble lu clear", load_use_stall, 0);
    stall = 0; flush = 0;
    tick();
    chk("after bubble valid", ex_valid, 1);
    chk("after bubble pc", ex_pc, 64'h2000);
    chk("after bubble aluop", ex_aluop, 4'b0110);

    // Stall for three cycles while ID inputs churn
    stall = 1;
    for (int k = 0; k < 3; k++) begin
      id_pc = 64'h3000 + 64'(k * 4); id_alu_op = 2'(k); id_valid = (k != 1);
      tick();
      chk($sformatf("stall%0d pc", k), ex_pc, 64'h2000);
      chk($sformatf("stall%0d aluop", k), ex_aluop, 4'b0110);
      chk($sformatf("stall%0d valid", k), ex_valid, 1);
    end
    stall = 0;
    id_valid = 1; id_pc = 64'h4000; id_alu_op = 2'b10; id_funct3 = 3'b111;
    tick();
    chk("release pc", ex_pc, 64'h4000);
    chk("release aluop", ex_aluop, 4'b0000);

    // Asynchronous reset mid-stall takes effect without a clock edge
    stall = 1;
    #2;
    rst_n = 0;
    #1;
    chk("async rst valid", ex_valid, 0);
    chk("async rst pc", ex_pc, 0);
    @(negedge clk);
    rst_n = 1; stall = 0;
    tick();
    chk("post rst load valid", ex_valid, 1);
    chk("post rst load pc", ex_pc, 64'h4000);
    flush = 1;
    tick();
    chk("flush only valid", ex_valid, 0);
    flush = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
